// File: rtl/dp_issue_if.sv
// Instruction offer channel into the data-processing issue sequencer.
// A word transfers on the cycle where instr_valid and instr_ready are both high.
interface dp_issue_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/dp_issue.sv
// Issue sequencer for ARM data-processing words: decode, condition check,
// register read, op-unit drive, write-back and N/Z/C flag ownership.
module dp_issue #(
    parameter int EXEC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    dp_issue_if.slave   ib,
    output logic [3:0]  rf_raddr_n,
    output logic [3:0]  rf_raddr_m,
    input  logic [31:0] rf_rdata_n,
    input  logic [31:0] rf_rdata_m,
    output logic        en_inst,
    output logic [3:0]  op_sel,
    output logic        IMM,
    output logic        S,
    output logic [31:0] Rn,
    output logic [31:0] Rm,
    output logic [11:0] imm_operand,
    output logic [4:0]  imm_shift,
    output logic [1:0]  stype,
    output logic        carry_in,
    output logic        zero_in,
    output logic        neg_in,
    input  logic [31:0] op_result,
    input  logic        op_carry,
    input  logic        op_zero,
    input  logic        op_neg,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        done,
    output logic        skipped,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        EXEC,
        WB,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] ir;
    logic [3:0]  cnt;
    logic [31:0] res;
    logic        res_c;
    logic        res_z;
    logic        res_n;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        writes;
    logic        cond_known;
    logic        cond_ok;
    logic        legal;
    logic        last;

    // TST/TEQ/CMP/CMN (1000-1011) only set flags
    assign writes = (ir[24:23] != 2'b10);
    assign last   = (cnt == 4'(EXEC_LAT - 1));

    always_comb begin
        cond_known = 1'b1;
        cond_ok    = 1'b0;
        case (ir[31:28])
            4'h0:    cond_ok = flag_z;
            4'h1:    cond_ok = ~flag_z;
            4'h2:    cond_ok = flag_c;
            4'h3:    cond_ok = ~flag_c;
            4'h4:    cond_ok = flag_n;
            4'h5:    cond_ok = ~flag_n;
            4'he:    cond_ok = 1'b1;
            default: cond_known = 1'b0;
        endcase
    end

    assign legal = (ir[27:26] == 2'b00)
                 && !(!ir[25] && ir[4])
                 && cond_known
                 && !(writes && ir[15:12] == 4'hf);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ib.instr_valid) state_nx = DECODE;
            DECODE:  state_nx = (legal && cond_ok) ? READ : DONE;
            READ:    state_nx = EXEC;
            EXEC:    if (last) state_nx = WB;
            WB:      state_nx = IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= '0;
            cnt    <= '0;
            Rn     <= '0;
            Rm     <= '0;
            res    <= '0;
            res_c  <= 1'b0;
            res_z  <= 1'b0;
            res_n  <= 1'b0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (ib.instr_valid) ir <= ib.instr;
                end
                READ: begin
                    Rn  <= rf_rdata_n;
                    Rm  <= rf_rdata_m;
                    cnt <= '0;
                end
                EXEC: begin
                    cnt <= cnt + 4'd1;
                    if (last) begin
                        res   <= op_result;
                        res_c <= op_carry;
                        res_z <= op_zero;
                        res_n <= op_neg;
                    end
                end
                WB: begin
                    if (ir[20]) begin
                        flag_c <= res_c;
                        flag_z <= res_z;
                        flag_n <= res_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ib.instr_ready = (state == IDLE);
    assign rf_raddr_n     = ir[19:16];
    assign rf_raddr_m     = ir[3:0];
    assign en_inst        = (state == EXEC);
    assign op_sel         = ir[24:21];
    assign IMM            = ir[25];
    assign S              = ir[20];
    assign imm_operand    = ir[11:0];
    assign imm_shift      = ir[11:7];
    assign stype          = ir[6:5];
    assign carry_in       = flag_c;
    assign zero_in        = flag_z;
    assign neg_in         = flag_n;
    assign rf_we          = (state == WB) && writes;
    assign rf_waddr       = ir[15:12];
    assign rf_wdata       = res;
    assign done           = (state == WB) || (state == DONE);
    // DONE is only reached when the word is illegal or its condition fails
    assign illegal        = (state == DONE) && !legal;
    assign skipped        = (state == DONE) && legal && !cond_ok;

endmodule
